// File: rtl/wb_commit_buffer_pkg.sv
// Shared core configuration and the writeback buffer entry type.
package wb_commit_buffer_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int GPR_NUM    = 32;
  localparam int GPR_AW     = $clog2(GPR_NUM);

  // One buffered result destined for the architectural regfile.
  typedef struct packed {
    logic                  we;
    logic [GPR_AW-1:0]     waddr;
    logic [DATA_WIDTH-1:0] wdata;
  } wb_entry_t;

endpackage

// File: rtl/wb_commit_buffer.sv
// In-order writeback buffer: accepts up to two results per cycle and drains
// up to the two oldest per cycle onto registered regfile write ports.
// Port 1 always carries the younger entry, so a same-register pair resolves
// to program order under the regfile's higher-port-wins rule.
// Optional build macro: WB_COMMIT_TRACE_EN adds registered trace ports and a
// 64-bit commit counter for difftest.
module wb_commit_buffer
  import wb_commit_buffer_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int WRITE_PORTS = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    flush_i,
  input  logic                                    hold_i,
  input  logic [WRITE_PORTS-1:0]                  enq_valid_i,
  input  logic [WRITE_PORTS-1:0]                  enq_we_i,
  input  logic [WRITE_PORTS-1:0][GPR_AW-1:0]      enq_waddr_i,
  input  logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0]  enq_wdata_i,
  output logic                                    enq_ready_o,
  output logic [WRITE_PORTS-1:0]                  we_o,
  output logic [WRITE_PORTS-1:0][GPR_AW-1:0]      waddr_o,
  output logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0]  wdata_o,
  output logic [$clog2(DEPTH):0]                  count_o
`ifdef WB_COMMIT_TRACE_EN
  ,
  output logic [WRITE_PORTS-1:0]                  trace_valid_o,
  output logic [WRITE_PORTS-1:0][GPR_AW-1:0]      trace_waddr_o,
  output logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0]  trace_wdata_o,
  output logic [63:0]                             trace_cnt_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t mem_q [DEPTH];
  wb_entry_t mem_d [DEPTH];
  wb_entry_t rd_entry;

  logic [PW-1:0] head_q, head_d, tail_q, tail_d, wr_ptr;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    enq_n, deq_n;
  logic          enq_ready;

  logic [WRITE_PORTS-1:0]                 we_q, we_d;
  logic [WRITE_PORTS-1:0][GPR_AW-1:0]     waddr_q, waddr_d;
  logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0] wdata_q, wdata_d;

  // Ready depends on registered occupancy only, so the producer never sees a
  // combinational path from its own valid back to ready.
  assign enq_ready = (count_q <= CW'(DEPTH - 2));

  // Next-state for pointers, occupancy, entry storage and the drain registers.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    mem_d    = mem_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    wr_ptr   = tail_q;
    rd_entry = '0;
    enq_n    = '0;
    deq_n    = '0;
    we_d     = '0;
    waddr_d  = '0;
    wdata_d  = '0;

    if (flush_i) begin
      // Flush wins over everything: drop buffered entries and this cycle's enqueue.
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (enq_ready) begin
        for (int k = 0; k < WRITE_PORTS; k++) begin
          if (enq_valid_i[k]) begin
            mem_d[wr_ptr] = '{we: enq_we_i[k], waddr: enq_waddr_i[k], wdata: enq_wdata_i[k]};
            wr_ptr        = wr_ptr + 1'b1;
            enq_n         = enq_n + 1'b1;
          end
        end
        tail_d = wr_ptr;
      end

      // Drain uses pre-update occupancy, so a fresh entry waits at least one edge.
      if (!hold_i) begin
        deq_n = (count_q >= CW'(2)) ? 2'd2 : count_q[1:0];
        for (int k = 0; k < WRITE_PORTS; k++) begin
          if (2'(k) < deq_n) begin
            rd_entry   = mem_q[head_q + PW'(k)];
            we_d[k]    = rd_entry.we && (rd_entry.waddr != '0);
            waddr_d[k] = rd_entry.waddr;
            wdata_d[k] = rd_entry.wdata;
          end
        end
        head_d = head_q + PW'(deq_n);
      end

      count_d = count_q + CW'(enq_n) - CW'(deq_n);
    end
  end

  // Control state and registered regfile write ports.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every flop samples pre-edge values
    // regardless of statement order.
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      we_q    <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: the entry array is deliberately not reset; occupancy alone decides
    // which slots are live, so stale data is never observed.
    mem_q <= mem_d;
  end

  assign enq_ready_o = enq_ready;
  assign we_o        = we_q;
  assign waddr_o     = waddr_q;
  assign wdata_o     = wdata_q;
  assign count_o     = count_q;

`ifdef WB_COMMIT_TRACE_EN
  logic [WRITE_PORTS-1:0] pop_d, pop_q;
  logic [63:0]            trace_cnt_d, trace_cnt_q;

  // Trace marks every popped slot, including entries that do not write a GPR.
  always_comb begin
    pop_d = '0;
    for (int k = 0; k < WRITE_PORTS; k++) begin
      pop_d[k] = (2'(k) < deq_n);
    end
    trace_cnt_d = trace_cnt_q + 64'(deq_n);
  end

  // Trace registers, aligned with the regfile write ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      pop_q       <= '0;
      trace_cnt_q <= '0;
    end else begin
      pop_q       <= pop_d;
      trace_cnt_q <= trace_cnt_d;
    end
  end

  assign trace_valid_o = pop_q;
  assign trace_waddr_o = waddr_q;
  assign trace_wdata_o = wdata_q;
  assign trace_cnt_o   = trace_cnt_q;
`endif

endmodule

// File: tb/tb_wb_commit_buffer.sv
// Self-checking bench for wb_commit_buffer: table-driven single-transaction
// vectors, hand-written multi-cycle sequences, and a scoreboard of expected
// regfile writes consumed as the DUT issues them.
module tb_wb_commit_buffer;
  import wb_commit_buffer_pkg::*;

  localparam int DEPTH = 8;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       flush_i;
  logic                       hold_i;
  logic [1:0]                 enq_valid_i;
  logic [1:0]                 enq_we_i;
  logic [1:0][GPR_AW-1:0]     enq_waddr_i;
  logic [1:0][DATA_WIDTH-1:0] enq_wdata_i;
  logic                       enq_ready_o;
  logic [1:0]                 we_o;
  logic [1:0][GPR_AW-1:0]     waddr_o;
  logic [1:0][DATA_WIDTH-1:0] wdata_o;
  logic [$clog2(DEPTH):0]     count_o;
`ifdef WB_COMMIT_TRACE_EN
  logic [1:0]                 trace_valid_o;
  logic [1:0][GPR_AW-1:0]     trace_waddr_o;
  logic [1:0][DATA_WIDTH-1:0] trace_wdata_o;
  logic [63:0]                trace_cnt_o;
`endif

  wb_commit_buffer #(.DEPTH(DEPTH), .WRITE_PORTS(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .hold_i      (hold_i),
    .enq_valid_i (enq_valid_i),
    .enq_we_i    (enq_we_i),
    .enq_waddr_i (enq_waddr_i),
    .enq_wdata_i (enq_wdata_i),
    .enq_ready_o (enq_ready_o),
    .we_o        (we_o),
    .waddr_o     (waddr_o),
    .wdata_o     (wdata_o),
    .count_o     (count_o)
`ifdef WB_COMMIT_TRACE_EN
    ,
    .trace_valid_o (trace_valid_o),
    .trace_waddr_o (trace_waddr_o),
    .trace_wdata_o (trace_wdata_o),
    .trace_cnt_o   (trace_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int m_count = 0;
  int m_popped = 0;
  logic [GPR_AW+DATA_WIDTH-1:0] sb[$];
  logic [DATA_WIDTH-1:0]        rf[GPR_NUM];

  typedef struct {
    logic [1:0]  v;
    logic [1:0]  we;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic [1:0]  exp_we;
    int          exp_cnt;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Consume issued writes against the scoreboard and update the regfile model
  // (port 1 applied last, so it wins on a shared address).
  task automatic monitor();
    logic [GPR_AW+DATA_WIDTH-1:0] exp;
    for (int k = 0; k < 2; k++) begin
      if (we_o[k]) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wb_write_port%0d: got unexpected write r%0d=0x%0h, required none",
                   k, waddr_o[k], wdata_o[k]);
        end else begin
          exp = sb.pop_front();
          check($sformatf("wb_write_port%0d", k), 64'({waddr_o[k], wdata_o[k]}), 64'(exp));
        end
        rf[waddr_o[k]] = wdata_o[k];
      end
    end
  endtask

  // Advance one clock: update the reference model from the driven inputs, then
  // sample #1 after the edge and compare occupancy/ready and issued writes.
  task automatic step();
    int  enq_n;
    int  deq_n;
    bit  rdy;
    rdy = (DEPTH - m_count) >= 2;
    if (rst) begin
      sb.delete();
      m_count  = 0;
      m_popped = 0;
    end else if (flush_i) begin
      sb.delete();
      m_count = 0;
    end else begin
      deq_n = hold_i ? 0 : ((m_count >= 2) ? 2 : m_count);
      enq_n = 0;
      if (rdy) begin
        for (int k = 0; k < 2; k++) begin
          if (enq_valid_i[k]) begin
            enq_n++;
            if (enq_we_i[k] && enq_waddr_i[k] != '0)
              sb.push_back({enq_waddr_i[k], enq_wdata_i[k]});
          end
        end
      end
      m_count  = m_count + enq_n - deq_n;
      m_popped = m_popped + deq_n;
    end
    @(posedge clk);
    #1;
    monitor();
    check("count_o", 64'(count_o), 64'(m_count));
    check("enq_ready_o", 64'(enq_ready_o), 64'((DEPTH - m_count) >= 2));
  endtask

  task automatic set_enq(input logic [1:0] v, input logic [1:0] we,
                         input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1);
    enq_valid_i    = v;
    enq_we_i       = we;
    enq_waddr_i[0] = a0;
    enq_wdata_i[0] = d0;
    enq_waddr_i[1] = a1;
    enq_wdata_i[1] = d1;
  endtask

  task automatic idle();
    set_enq(2'b00, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < GPR_NUM; i++) rf[i] = '0;
    tbl[0] = '{2'b11, 2'b11, 5'd5, 32'h11, 5'd6, 32'h22, 2'b11, 2};
    tbl[1] = '{2'b11, 2'b11, 5'd3, 32'hA,  5'd3, 32'hB,  2'b11, 2};
    tbl[2] = '{2'b11, 2'b01, 5'd0, 32'hFF, 5'd7, 32'h5,  2'b00, 2};
    tbl[3] = '{2'b10, 2'b10, 5'd0, 32'h0,  5'd4, 32'h44, 2'b01, 1};
    tbl[4] = '{2'b01, 2'b00, 5'd8, 32'h88, 5'd0, 32'h0,  2'b00, 1};
    tbl[5] = '{2'b11, 2'b10, 5'd2, 32'h2,  5'd9, 32'h99, 2'b10, 2};

    rst = 1'b1; flush_i = 1'b0; hold_i = 1'b0;
    idle();
    step();
    step();
    rst = 1'b0;
    check("reset_count", 64'(count_o), 64'(0));
    check("reset_ready", 64'(enq_ready_o), 64'(1));
    check("reset_we", 64'(we_o), 64'(0));
    check("reset_waddr", 64'(waddr_o), 64'(0));
    check("reset_wdata", 64'(wdata_o), 64'(0));

    // Single-transaction vectors: enqueue, then observe the drain one edge later.
    for (int i = 0; i < 6; i++) begin
      set_enq(tbl[i].v, tbl[i].we, tbl[i].a0, tbl[i].d0, tbl[i].a1, tbl[i].d1);
      step();
      idle();
      check($sformatf("vec%0d_count_after_enq", i), 64'(count_o), 64'(tbl[i].exp_cnt));
      check($sformatf("vec%0d_we_before_drain", i), 64'(we_o), 64'(0));
      step();
      check($sformatf("vec%0d_we_o", i), 64'(we_o), 64'(tbl[i].exp_we));
      check($sformatf("vec%0d_count_after_drain", i), 64'(count_o), 64'(0));
      if (i == 0) begin
        check("vec0_waddr_o", 64'(waddr_o), 64'({5'd6, 5'd5}));
        check("vec0_wdata_o", 64'(wdata_o), 64'({32'h22, 32'h11}));
      end
      if (i == 1) check("vec1_rf_r3", 64'(rf[3]), 64'(32'hB));
    end

    // Hold to 7 entries, attempt an illegal enqueue, then drain.
    hold_i = 1'b1;
    for (int p = 0; p < 3; p++) begin
      set_enq(2'b11, 2'b11, 5'(10 + 2 * p), 32'h100 + 32'(2 * p),
              5'(11 + 2 * p), 32'h101 + 32'(2 * p));
      step();
      check("hold_we_o", 64'(we_o), 64'(0));
    end
    set_enq(2'b01, 2'b01, 5'd16, 32'h106, 5'd0, 32'h0);
    step();
    check("hold7_count", 64'(count_o), 64'(7));
    check("hold7_ready", 64'(enq_ready_o), 64'(0));
    set_enq(2'b11, 2'b11, 5'd30, 32'hDEAD, 5'd31, 32'hBEEF);
    step();
    idle();
    check("hold7_ignored_enq", 64'(count_o), 64'(7));
    hold_i = 1'b0;
    for (int j = 0; j < 4; j++) begin
      step();
      check($sformatf("drain7_step%0d_count", j), 64'(count_o), 64'((j < 3) ? 5 - 2 * j : 0));
    end
    check("drain7_sb_empty", 64'(sb.size()), 64'(0));

    // Fill all 8 entries under hold, then release: 8 -> 6 -> 4 -> 2 -> 0.
    hold_i = 1'b1;
    for (int p = 0; p < 4; p++) begin
      set_enq(2'b11, 2'b11, 5'(10 + 2 * p), 32'h200 + 32'(2 * p),
              5'(11 + 2 * p), 32'h201 + 32'(2 * p));
      step();
    end
    idle();
    check("full_count", 64'(count_o), 64'(8));
    check("full_ready", 64'(enq_ready_o), 64'(0));
    hold_i = 1'b0;
    for (int j = 0; j < 4; j++) begin
      step();
      check($sformatf("drain8_step%0d_we", j), 64'(we_o), 64'(2'b11));
      check($sformatf("drain8_step%0d_count", j), 64'(count_o), 64'(6 - 2 * j));
    end
    step();
    check("drain8_idle_we", 64'(we_o), 64'(0));
    check("drain8_sb_empty", 64'(sb.size()), 64'(0));

    // Flush with 5 buffered entries and a concurrent enqueue.
    hold_i = 1'b1;
    set_enq(2'b11, 2'b11, 5'd11, 32'h311, 5'd12, 32'h312); step();
    set_enq(2'b11, 2'b11, 5'd13, 32'h313, 5'd14, 32'h314); step();
    set_enq(2'b01, 2'b01, 5'd15, 32'h315, 5'd0, 32'h0);    step();
    check("preflush_count", 64'(count_o), 64'(5));
    hold_i  = 1'b0;
    flush_i = 1'b1;
    set_enq(2'b11, 2'b11, 5'd20, 32'h320, 5'd21, 32'h321);
    step();
    flush_i = 1'b0;
    idle();
    check("flush_count", 64'(count_o), 64'(0));
    check("flush_we", 64'(we_o), 64'(0));
    step();
    check("postflush_we", 64'(we_o), 64'(0));
    set_enq(2'b01, 2'b01, 5'd9, 32'h9, 5'd0, 32'h0);
    step();
    idle();
    step();
    check("postflush_r9_we", 64'(we_o), 64'(2'b01));
    check("postflush_r9_waddr", 64'(waddr_o[0]), 64'(9));
    check("postflush_r9_wdata", 64'(wdata_o[0]), 64'(9));

    // Reset mid-operation drops buffered data.
    hold_i = 1'b1;
    for (int p = 0; p < 3; p++) begin
      set_enq(2'b11, 2'b11, 5'(22 + p), 32'h400, 5'(25 + p), 32'h401);
      step();
    end
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    hold_i = 1'b0;
    check("midrst_count", 64'(count_o), 64'(0));
    check("midrst_ready", 64'(enq_ready_o), 64'(1));
    check("midrst_we", 64'(we_o), 64'(0));
    step();
    check("midrst_no_drain", 64'(we_o), 64'(0));

    // Wrap-around: 20 single-lane enqueues alternating with drains.
    for (int i = 1; i <= 20; i++) begin
      set_enq(2'b01, 2'b01, 5'(i), 32'(i), 5'd0, 32'h0);
      step();
      idle();
      step();
      check($sformatf("wrap%0d_we", i), 64'(we_o), 64'(2'b01));
    end
    check("wrap_sb_empty", 64'(sb.size()), 64'(0));
    check("wrap_rf_r1", 64'(rf[1]), 64'(1));
    check("wrap_rf_r20", 64'(rf[20]), 64'(20));
`ifdef WB_COMMIT_TRACE_EN
    check("wrap_trace_cnt", trace_cnt_o, 64'(20));
    check("wrap_trace_cnt_model", trace_cnt_o, 64'(m_popped));
`endif

    check("final_sb_empty", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
